// File: rtl/rs_wakeup_select.sv
// =============================================================================
// Module      : rs_wakeup_select
// Description : Reservation station with multi-CDB/commit wakeup, dispatch
//               bypass, age-ordered selection and valid/ready issue.
// Revision    : 1.0
// =============================================================================
`default_nettype none

module rs_wakeup_select #(
    parameter int SIZE    = 4,
    parameter int NUM_CDB = 2,
    parameter int WIDTH   = 16,
    parameter int TAG_W   = 3,
    parameter int OP_W    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OP_W-1:0]            disp_op,
    input  logic [WIDTH-1:0]           disp_vj,
    input  logic [WIDTH-1:0]           disp_vk,
    input  logic [WIDTH-1:0]           disp_pc,
    input  logic [TAG_W-1:0]           disp_qj,
    input  logic [TAG_W-1:0]           disp_qk,
    input  logic [TAG_W-1:0]           disp_dest,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*WIDTH-1:0]   cdb_value,
    input  logic                       commit_valid,
    input  logic [TAG_W-1:0]           commit_tag,
    input  logic [WIDTH-1:0]           commit_value,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [OP_W-1:0]            iss_op,
    output logic [WIDTH-1:0]           iss_vj,
    output logic [WIDTH-1:0]           iss_vk,
    output logic [WIDTH-1:0]           iss_pc,
    output logic [TAG_W-1:0]           iss_dest,
    output logic [$clog2(SIZE+1)-1:0]  count
);

    localparam int               CNT_W   = $clog2(SIZE+1);
    localparam int               IDX_W   = $clog2(SIZE);
    localparam logic [TAG_W-1:0] INV_TAG = '1;

    logic [SIZE-1:0]  busy_q, busy_d, rj_q, rj_d, rk_q, rk_d;
    logic [OP_W-1:0]  op_q   [SIZE];
    logic [OP_W-1:0]  op_d   [SIZE];
    logic [WIDTH-1:0] vj_q   [SIZE];
    logic [WIDTH-1:0] vj_d   [SIZE];
    logic [WIDTH-1:0] vk_q   [SIZE];
    logic [WIDTH-1:0] vk_d   [SIZE];
    logic [WIDTH-1:0] pc_q   [SIZE];
    logic [WIDTH-1:0] pc_d   [SIZE];
    logic [TAG_W-1:0] qj_q   [SIZE];
    logic [TAG_W-1:0] qj_d   [SIZE];
    logic [TAG_W-1:0] qk_q   [SIZE];
    logic [TAG_W-1:0] qk_d   [SIZE];
    logic [TAG_W-1:0] dest_q [SIZE];
    logic [TAG_W-1:0] dest_d [SIZE];
    logic [SIZE-1:0]  older_q [SIZE];
    logic [SIZE-1:0]  older_d [SIZE];

    logic [SIZE-1:0]  ready_w, sel_w;
    logic [IDX_W-1:0] alloc_idx_w;
    logic             disp_fire_w, iss_fire_w;
    logic [WIDTH:0]   snp_j_w, snp_k_w;

    // Returns {hit, value}; lowest CDB index wins, commit is the fallback.
    function automatic logic [WIDTH:0] snoop(input logic [TAG_W-1:0] tag);
        logic [WIDTH:0] res;
        res = '0;
        if (tag != INV_TAG) begin
            if (commit_valid && commit_tag == tag)
                res = {1'b1, commit_value};
            for (int b = NUM_CDB-1; b >= 0; b--)
                if (cdb_valid[b] && cdb_tag[b*TAG_W +: TAG_W] == tag)
                    res = {1'b1, cdb_value[b*WIDTH +: WIDTH]};
        end
        return res;
    endfunction

    assign ready_w     = busy_q & rj_q & rk_q;
    assign disp_ready  = ~(&busy_q);
    assign iss_valid   = |ready_w;
    assign disp_fire_w = disp_valid && disp_ready && !flush;
    assign iss_fire_w  = iss_valid && iss_ready && !flush;

    always_comb begin
        alloc_idx_w = '0;
        for (int i = SIZE-1; i >= 0; i--)
            if (!busy_q[i]) alloc_idx_w = IDX_W'(i);
    end

    // An entry is selected when it is older than every other ready entry.
    always_comb begin
        sel_w = '0;
        for (int i = 0; i < SIZE; i++) begin
            sel_w[i] = ready_w[i];
            for (int j = 0; j < SIZE; j++)
                if (j != i && ready_w[j] && !older_q[i][j]) sel_w[i] = 1'b0;
        end
    end

    always_comb begin
        iss_op   = '0;
        iss_vj   = '0;
        iss_vk   = '0;
        iss_pc   = '0;
        iss_dest = '0;
        count    = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (sel_w[i]) begin
                iss_op   = iss_op   | op_q[i];
                iss_vj   = iss_vj   | vj_q[i];
                iss_vk   = iss_vk   | vk_q[i];
                iss_pc   = iss_pc   | pc_q[i];
                iss_dest = iss_dest | dest_q[i];
            end
            count = count + CNT_W'(busy_q[i]);
        end
    end

    always_comb begin
        busy_d  = busy_q;
        rj_d    = rj_q;
        rk_d    = rk_q;
        op_d    = op_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        pc_d    = pc_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        dest_d  = dest_q;
        older_d = older_q;
        snp_j_w = '0;
        snp_k_w = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (busy_q[i] && !rj_q[i]) begin
                snp_j_w = snoop(qj_q[i]);
                if (snp_j_w[WIDTH]) begin
                    vj_d[i] = snp_j_w[WIDTH-1:0];
                    rj_d[i] = 1'b1;
                end
            end
            if (busy_q[i] && !rk_q[i]) begin
                snp_k_w = snoop(qk_q[i]);
                if (snp_k_w[WIDTH]) begin
                    vk_d[i] = snp_k_w[WIDTH-1:0];
                    rk_d[i] = 1'b1;
                end
            end
            if (iss_fire_w && sel_w[i]) begin
                busy_d[i] = 1'b0;
                rj_d[i]   = 1'b0;
                rk_d[i]   = 1'b0;
                qj_d[i]   = INV_TAG;
                qk_d[i]   = INV_TAG;
            end
        end
        if (disp_fire_w) begin
            busy_d[alloc_idx_w] = 1'b1;
            op_d[alloc_idx_w]   = disp_op;
            pc_d[alloc_idx_w]   = disp_pc;
            dest_d[alloc_idx_w] = disp_dest;
            qj_d[alloc_idx_w]   = disp_qj;
            qk_d[alloc_idx_w]   = disp_qk;
            snp_j_w = snoop(disp_qj);
            snp_k_w = snoop(disp_qk);
            vj_d[alloc_idx_w] = snp_j_w[WIDTH] ? snp_j_w[WIDTH-1:0] : disp_vj;
            vk_d[alloc_idx_w] = snp_k_w[WIDTH] ? snp_k_w[WIDTH-1:0] : disp_vk;
            rj_d[alloc_idx_w] = (disp_qj == INV_TAG) || snp_j_w[WIDTH];
            rk_d[alloc_idx_w] = (disp_qk == INV_TAG) || snp_k_w[WIDTH];
            // New entry is younger than every entry currently resident.
            older_d[alloc_idx_w] = '0;
            for (int j = 0; j < SIZE; j++)
                older_d[j][alloc_idx_w] = busy_q[j];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            busy_q <= '0;
            rj_q   <= '0;
            rk_q   <= '0;
            for (int i = 0; i < SIZE; i++) begin
                op_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                pc_q[i]    <= '0;
                qj_q[i]    <= INV_TAG;
                qk_q[i]    <= INV_TAG;
                dest_q[i]  <= '0;
                older_q[i] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            rj_q    <= rj_d;
            rk_q    <= rk_d;
            op_q    <= op_d;
            vj_q    <= vj_d;
            vk_q    <= vk_d;
            pc_q    <= pc_d;
            qj_q    <= qj_d;
            qk_q    <= qk_d;
            dest_q  <= dest_d;
            older_q <= older_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_wakeup_select.sv
// =============================================================================
// Module      : tb_rs_wakeup_select
// Description : Scoreboard bench for rs_wakeup_select (SIZE=4, 2 CDBs).
// Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_rs_wakeup_select;

    localparam int SIZE = 4, NUM_CDB = 2, WIDTH = 16, TAG_W = 3, OP_W = 4;
    localparam logic [TAG_W-1:0] INV = '1;

    logic                     clk = 1'b0;
    logic                     rst_n, flush, disp_valid, disp_ready;
    logic [OP_W-1:0]          disp_op;
    logic [WIDTH-1:0]         disp_vj, disp_vk, disp_pc;
    logic [TAG_W-1:0]         disp_qj, disp_qk, disp_dest;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*WIDTH-1:0] cdb_value;
    logic                     commit_valid;
    logic [TAG_W-1:0]         commit_tag;
    logic [WIDTH-1:0]         commit_value;
    logic                     iss_valid, iss_ready;
    logic [OP_W-1:0]          iss_op;
    logic [WIDTH-1:0]         iss_vj, iss_vk, iss_pc;
    logic [TAG_W-1:0]         iss_dest;
    logic [$clog2(SIZE+1)-1:0] count;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] vj;
        logic [WIDTH-1:0] vk;
        logic [WIDTH-1:0] pc;
        logic [TAG_W-1:0] dest;
    } iss_t;

    iss_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    rs_wakeup_select #(.SIZE(SIZE), .NUM_CDB(NUM_CDB), .WIDTH(WIDTH),
                       .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_pc(disp_pc),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_dest(disp_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_value(commit_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_pc(iss_pc),
        .iss_dest(iss_dest), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every accepted issue is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && !flush && iss_valid && iss_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_issue", {61'd0, iss_dest}, 64'hFFFF);
            end else begin
                iss_t e;
                e = sb.pop_front();
                check("iss_op",   64'(iss_op),   64'(e.op));
                check("iss_vj",   64'(iss_vj),   64'(e.vj));
                check("iss_vk",   64'(iss_vk),   64'(e.vk));
                check("iss_pc",   64'(iss_pc),   64'(e.pc));
                check("iss_dest", 64'(iss_dest), 64'(e.dest));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid   = 1'b0;
        cdb_valid    = '0;
        cdb_tag      = '0;
        cdb_value    = '0;
        commit_valid = 1'b0;
        commit_tag   = '0;
        commit_value = '0;
        iss_ready    = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] qj,
                            input logic [TAG_W-1:0] qk, input logic [WIDTH-1:0] vj,
                            input logic [WIDTH-1:0] vk, input logic [TAG_W-1:0] dest);
        disp_valid = 1'b1;
        disp_op    = op;
        disp_qj    = qj;
        disp_qk    = qk;
        disp_vj    = vj;
        disp_vk    = vk;
        disp_dest  = dest;
        disp_pc    = 16'h1000 + 16'(dest);
    endtask

    function automatic iss_t rec(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] vj,
                                 input logic [WIDTH-1:0] vk, input logic [TAG_W-1:0] dest);
        rec = '{op: op, vj: vj, vk: vk, pc: 16'h1000 + 16'(dest), dest: dest};
    endfunction

    initial begin
        idle();
        set_disp(4'd0, INV, INV, 16'd0, 16'd0, 3'd0);
        disp_valid = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_disp_ready", 64'(disp_ready), 64'd1);
        check("rst_iss_valid",  64'(iss_valid),  64'd0);
        check("rst_count",      64'(count),      64'd0);
        check("rst_iss_vj",     64'(iss_vj),     64'd0);
        check("rst_iss_dest",   64'(iss_dest),   64'd0);

        // Ready-at-dispatch entry issues the following cycle
        step();
        set_disp(4'd3, INV, INV, 16'h0011, 16'h0022, 3'd2);
        sb.push_back(rec(4'd3, 16'h0011, 16'h0022, 3'd2));
        step();
        disp_valid = 1'b0;
        iss_ready  = 1'b1;
        @(negedge clk);
        check("t1_iss_valid", 64'(iss_valid), 64'd1);
        check("t1_iss_vj",    64'(iss_vj),    64'h0011);
        check("t1_iss_dest",  64'(iss_dest),  64'd2);
        check("t1_count",     64'(count),     64'd1);
        step();
        iss_ready = 1'b0;
        @(negedge clk);
        check("t1_count_after", 64'(count),     64'd0);
        check("t1_valid_after", 64'(iss_valid), 64'd0);

        // CDB wakeup on bus 1; bus 0 carries the same tag but is not valid
        step();
        set_disp(4'd5, 3'd4, INV, 16'h0000, 16'h0022, 3'd3);
        step();
        disp_valid = 1'b0;
        @(negedge clk);
        check("t2_waiting", 64'(iss_valid), 64'd0);
        step();
        cdb_valid = 2'b10;
        cdb_tag   = {3'd4, 3'd4};
        cdb_value = {16'hBEEF, 16'hDEAD};
        sb.push_back(rec(4'd5, 16'hBEEF, 16'h0022, 3'd3));
        step();
        cdb_valid = '0;
        iss_ready = 1'b1;
        @(negedge clk);
        check("t2_iss_valid", 64'(iss_valid), 64'd1);
        check("t2_iss_vj",    64'(iss_vj),    64'hBEEF);
        step();
        iss_ready = 1'b0;

        // Dispatch bypass: CDB (two buses match, bus 0 wins) and commit
        set_disp(4'd7, 3'd5, 3'd6, 16'h0001, 16'h0002, 3'd1);
        cdb_valid    = 2'b11;
        cdb_tag      = {3'd5, 3'd5};
        cdb_value    = {16'hAAAA, 16'h1234};
        commit_valid = 1'b1;
        commit_tag   = 3'd6;
        commit_value = 16'h5678;
        sb.push_back(rec(4'd7, 16'h1234, 16'h5678, 3'd1));
        step();
        idle();
        iss_ready = 1'b1;
        @(negedge clk);
        check("t3_bypass_valid", 64'(iss_valid), 64'd1);
        step();
        iss_ready = 1'b0;

        // Age order: A waits on tag 1, B and C ready
        set_disp(4'd1, 3'd1, INV, 16'h0000, 16'h0A0B, 3'd4);
        step();
        set_disp(4'd2, INV, INV, 16'h0B01, 16'h0B02, 3'd5);
        step();
        set_disp(4'd4, INV, INV, 16'h0C01, 16'h0C02, 3'd6);
        step();
        disp_valid = 1'b0;
        @(negedge clk);
        check("t4_hold_dest", 64'(iss_dest), 64'd5);
        check("t4_count",     64'(count),    64'd3);
        step();
        @(negedge clk);
        check("t4_stable_dest", 64'(iss_dest), 64'd5);
        step();
        // B accepted while tag 1 broadcasts; CDB beats commit for A
        cdb_valid    = 2'b10;
        cdb_tag      = {3'd1, 3'd0};
        cdb_value    = {16'h0A0A, 16'h0000};
        commit_valid = 1'b1;
        commit_tag   = 3'd1;
        commit_value = 16'hFFFF;
        iss_ready    = 1'b1;
        sb.push_back(rec(4'd2, 16'h0B01, 16'h0B02, 3'd5));
        sb.push_back(rec(4'd1, 16'h0A0A, 16'h0A0B, 3'd4));
        sb.push_back(rec(4'd4, 16'h0C01, 16'h0C02, 3'd6));
        step();
        cdb_valid    = '0;
        commit_valid = 1'b0;
        step(); step();
        iss_ready = 1'b0;
        @(negedge clk);
        check("t4_drained", 64'(count), 64'd0);

        // Full station: extra dispatch ignored, issue+dispatch drops count
        for (int i = 0; i < SIZE; i++) begin
            set_disp(4'(8 + i), 3'd2, INV, 16'h0000, 16'(i), 3'(i));
            step();
        end
        set_disp(4'd15, INV, INV, 16'hEEEE, 16'hEEEE, 3'd7);
        @(negedge clk);
        check("t5_full_ready", 64'(disp_ready), 64'd0);
        check("t5_full_count", 64'(count),      64'd4);
        check("t5_not_ready",  64'(iss_valid),  64'd0);
        step();
        @(negedge clk);
        check("t5_ignored_count", 64'(count), 64'd4);
        step();
        disp_valid = 1'b0;
        cdb_valid  = 2'b01;
        cdb_tag    = {3'd0, 3'd2};
        cdb_value  = {16'h0000, 16'h2222};
        for (int i = 0; i < SIZE; i++)
            sb.push_back(rec(4'(8 + i), 16'h2222, 16'(i), 3'(i)));
        step();
        cdb_valid  = '0;
        iss_ready  = 1'b1;
        disp_valid = 1'b1;
        step();
        iss_ready  = 1'b0;
        disp_valid = 1'b0;
        @(negedge clk);
        check("t5_issue_count", 64'(count),      64'd3);
        check("t5_ready_again", 64'(disp_ready), 64'd1);
        step();
        iss_ready = 1'b1;
        step(); step(); step();
        iss_ready = 1'b0;
        @(negedge clk);
        check("t5_drained", 64'(count), 64'd0);

        // Flush dominates dispatch and issue
        for (int i = 0; i < 3; i++) begin
            set_disp(4'd9, INV, INV, 16'h0900, 16'h0900, 3'(i));
            step();
        end
        flush      = 1'b1;
        iss_ready  = 1'b1;
        disp_valid = 1'b1;
        sb.delete();
        step();
        idle();
        @(negedge clk);
        check("t6_flush_count", 64'(count),      64'd0);
        check("t6_flush_valid", 64'(iss_valid),  64'd0);
        check("t6_flush_ready", 64'(disp_ready), 64'd1);

        // Reset mid-traffic
        step();
        set_disp(4'd6, 3'd3, INV, 16'h0000, 16'h0000, 3'd0);
        step();
        set_disp(4'd6, INV, INV, 16'h0600, 16'h0600, 3'd1);
        step();
        rst_n     = 1'b0;
        iss_ready = 1'b1;
        step();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        check("t6_rst_count", 64'(count),     64'd0);
        check("t6_rst_valid", 64'(iss_valid), 64'd0);

        // Station usable after reset
        step();
        set_disp(4'd10, INV, INV, 16'h0ABC, 16'h0DEF, 3'd3);
        sb.push_back(rec(4'd10, 16'h0ABC, 16'h0DEF, 3'd3));
        step();
        disp_valid = 1'b0;
        iss_ready  = 1'b1;
        step();
        iss_ready = 1'b0;
        step();
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
